// File: rtl/parallel_pe_mac.sv
// 32-lane signed multiply-accumulate processing element: lane products are
// reduced to a beat sum, accumulated across beats, and emitted on the last beat.
module parallel_pe_mac #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*DW-1:0]   neuron,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [1:0]            ctl,
  input  logic                  vld_i,
  output logic [ACC_W-1:0]      result,
  output logic                  vld_o
);

  typedef enum logic [1:0] {
    BEAT_MIDDLE = 2'b00,
    BEAT_FIRST  = 2'b01,
    BEAT_LAST   = 2'b10,
    BEAT_SINGLE = 2'b11
  } beat_e;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             vld_q, vld_d;
  logic [ACC_W-1:0] beat_sum;
  logic signed [DW-1:0]    n_lane, w_lane;
  logic signed [ACC_W-1:0] n_ext, w_ext, prod;
  beat_e            beat;

  // Lanes are sign-extended to the accumulator width before multiplying so the
  // product and the tree sum wrap modulo 2^ACC_W.
  always_comb begin
    beat_sum = '0;
    n_lane   = '0;
    w_lane   = '0;
    n_ext    = '0;
    w_ext    = '0;
    prod     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n_lane   = neuron[i*DW +: DW];
      w_lane   = weight[i*DW +: DW];
      n_ext    = ACC_W'(n_lane);
      w_ext    = ACC_W'(w_lane);
      prod     = n_ext * w_ext;
      beat_sum = beat_sum + prod;
    end
  end

  always_comb begin
    beat     = beat_e'(ctl);
    acc_d    = acc_q;
    result_d = result_q;
    vld_d    = 1'b0;
    if (vld_i) begin
      unique case (beat)
        BEAT_FIRST:  acc_d = beat_sum;
        BEAT_MIDDLE: acc_d = acc_q + beat_sum;
        BEAT_LAST: begin
          result_d = acc_q + beat_sum;
          vld_d    = 1'b1;
          acc_d    = '0;
        end
        BEAT_SINGLE: begin
          result_d = beat_sum;
          vld_d    = 1'b1;
          acc_d    = '0;
        end
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
      vld_q    <= vld_d;
    end
  end

  assign result = result_q;
  assign vld_o  = vld_q;

endmodule

// File: tb/tb_parallel_pe_mac.sv
// Directed and randomized checks of parallel_pe_mac against a dot-product model.
module tb_parallel_pe_mac;

  logic         clk;
  logic         rst_n;
  logic [511:0] neuron;
  logic [511:0] weight;
  logic [1:0]   ctl;
  logic         vld_i;
  logic [31:0]  result;
  logic         vld_o;

  int checks;
  int errors;
  int vld_count;

  // Reference state: running group total as an unbounded integer.
  longint       m_total;
  logic [31:0]  m_res;
  logic         m_vld;

  parallel_pe_mac #(.LANES(32), .DW(16), .ACC_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .neuron (neuron),
    .weight (weight),
    .ctl    (ctl),
    .vld_i  (vld_i),
    .result (result),
    .vld_o  (vld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic longint dot(input logic [511:0] n, input logic [511:0] w);
    longint s;
    logic signed [15:0] a, b;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      a = n[16*i +: 16];
      b = w[16*i +: 16];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] n16, input logic [15:0] w16);
    for (int i = 0; i < 32; i++) begin
      neuron[16*i +: 16] = n16;
      weight[16*i +: 16] = w16;
    end
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 32; i++) begin
      neuron[16*i +: 16] = 16'($urandom);
      weight[16*i +: 16] = 16'($urandom);
    end
  endtask

  // Drive one cycle, update the model from the beat rules, check after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] c);
    longint s;
    @(negedge clk);
    vld_i = v;
    ctl   = c;
    s     = dot(neuron, weight);
    m_vld = 1'b0;
    if (v) begin
      if (c[0] && !c[1]) m_total = s;
      else if (!c[1])    m_total = m_total + s;
      else begin
        m_res   = c[0] ? s[31:0] : 32'(m_total + s);
        m_vld   = 1'b1;
        m_total = 0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, m_res);
    check({tag, ".vld_o"}, {31'b0, vld_o}, {31'b0, m_vld});
    if (vld_o) vld_count++;
  endtask

  task automatic group4(input string tag);
    rand_vec(); step(tag, 1'b1, 2'b01);
    rand_vec(); step(tag, 1'b1, 2'b00);
    rand_vec(); step(tag, 1'b1, 2'b00);
    rand_vec(); step(tag, 1'b1, 2'b10);
  endtask

  initial begin
    checks = 0; errors = 0; vld_count = 0;
    m_total = 0; m_res = '0; m_vld = 1'b0;
    rst_n = 1'b0; vld_i = 1'b0; ctl = 2'b00;
    neuron = '0; weight = '0;
    #12;
    check("reset.result", result, 32'h0);
    check("reset.vld_o", {31'b0, vld_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones group
    fill(16'h0001, 16'h0001);
    step("ones.b1", 1'b1, 2'b01);
    step("ones.b2", 1'b1, 2'b00);
    step("ones.b3", 1'b1, 2'b00);
    step("ones.b4", 1'b1, 2'b10);
    check("ones.const", result, 32'h0000_0080);
    step("ones.idle", 1'b0, 2'b10);

    // Signed lanes
    fill(16'hFFFF, 16'h0002);
    step("neg.b1", 1'b1, 2'b01);
    step("neg.b2", 1'b1, 2'b00);
    step("neg.b3", 1'b1, 2'b00);
    step("neg.b4", 1'b1, 2'b10);
    check("neg.const", result, 32'hFFFF_FF00);

    // Four random groups separated by one idle cycle
    vld_count = 0;
    for (int g = 0; g < 4; g++) begin
      group4("rand");
      rand_vec();
      step("rand.idle", 1'b0, 2'b11);
    end
    check("rand.vld_count", 32'(vld_count), 32'd4);

    // Single-beat output, then a fresh group starting right after it
    neuron = '0; weight = '0;
    neuron[15:0] = 16'd3;
    weight[15:0] = 16'h7FFF;
    step("single", 1'b1, 2'b11);
    check("single.const", result, 32'h0001_7FFD);
    fill(16'h0001, 16'h0001);
    step("fresh.b1", 1'b1, 2'b01);
    step("fresh.b2", 1'b1, 2'b10);
    check("fresh.const", result, 32'h0000_0040);

    // Back-to-back last beats keep vld_o high; middle/last with no first
    rand_vec(); step("b2b.s1", 1'b1, 2'b11);
    rand_vec(); step("b2b.s2", 1'b1, 2'b11);
    rand_vec(); step("nofirst.b1", 1'b1, 2'b00);
    rand_vec(); step("nofirst.b2", 1'b1, 2'b10);

    // Idle gaps between middle beats
    rand_vec(); step("gap.b1", 1'b1, 2'b01);
    rand_vec(); step("gap.b2", 1'b1, 2'b00);
    for (int k = 0; k < 3; k++) begin
      rand_vec(); step("gap.idle", 1'b0, 2'b10);
    end
    rand_vec(); step("gap.b3", 1'b1, 2'b00);
    rand_vec(); step("gap.b4", 1'b1, 2'b10);

    // Extreme lanes to exercise wrap-around
    fill(16'h8000, 16'h8000);
    step("wrap.b1", 1'b1, 2'b01);
    step("wrap.b2", 1'b1, 2'b10);
    check("wrap.const", result, 32'h0000_0000);

    // Reset in the middle of a group, checked before any clock edge
    fill(16'h0001, 16'h0001);
    step("rst.b1", 1'b1, 2'b01);
    step("rst.b2", 1'b1, 2'b10);
    step("rst.b3", 1'b1, 2'b01);
    step("rst.b4", 1'b1, 2'b00);
    @(negedge clk);
    vld_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.mid.result", result, 32'h0);
    check("rst.mid.vld_o", {31'b0, vld_o}, 32'h0);
    m_total = 0; m_res = '0; m_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post.b1", 1'b1, 2'b01);
    step("post.b2", 1'b1, 2'b00);
    step("post.b3", 1'b1, 2'b00);
    step("post.b4", 1'b1, 2'b10);
    check("post.const", result, 32'h0000_0080);
    step("post.idle", 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
